// File: rtl/img_proc_pkg.sv
// Shared constants, FSM state type and width helpers for the image-processing blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default frame geometry, the filter pipeline-fill latency that both
// the 3x3 filters and the frame writer rely on, the border fill value, and the
// frame writer's state enum.
package img_proc_pkg;

    localparam int DATA_W = 10;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int ADDR_W = 19;

    // Pipeline-fill latency of a 3x3 window: two full line buffers plus the
    // three-tap horizontal window and its output register.
    function automatic int pipe_lat(input int img_w);
        return 2 * img_w + 3;
    endfunction

    localparam int PIPE_LAT = pipe_lat(IMG_W);

    localparam logic [DATA_W-1:0] BORDER_VAL = '1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } frame_state_e;

endpackage

// File: rtl/raster_xy_counter.sv
// Raster position counter: column x, row y and linear pixel index lin.
// Latency: outputs are registered; a position advances one edge after en.
// Backpressure: none; en simply freezes the position, clr returns it to 0,0,0.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   clr            synchronous return to the frame origin (wins over en)
//   en             advance one pixel
//   x, y, lin      current column, row and linear index
//   eol, eof       current pixel is the last of its line / of the frame
module raster_xy_counter #(
    parameter int IMG_W  = img_proc_pkg::IMG_W,
    parameter int IMG_H  = img_proc_pkg::IMG_H,
    parameter int ADDR_W = img_proc_pkg::ADDR_W,
    parameter int X_W    = img_proc_pkg::cnt_w(IMG_W),
    parameter int Y_W    = img_proc_pkg::cnt_w(IMG_H)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              en,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] lin,
    output logic              eol,
    output logic              eof
);

    assign eol = (x == X_W'(IMG_W - 1));
    assign eof = eol && (y == Y_W'(IMG_H - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x   <= '0;
            y   <= '0;
            lin <= '0;
        end else if (clr) begin
            x   <= '0;
            y   <= '0;
            lin <= '0;
        end else if (en) begin
            lin <= lin + ADDR_W'(1);
            if (eol) begin
                x <= '0;
                // Wrap the row at end of frame so a free-running user sees a
                // clean restart at the origin.
                y <= eof ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/filt_frame_writer.sv
// Frame writer: drops the 3x3 filter fill latency, then writes one frame to RAM with a constant border.
// Latency: first write strobe PIPE_LAT+1 cycles after start; each pixel is written one cycle after sampling.
// Backpressure: none; the source never stalls and the RAM port accepts a write every cycle.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              pulse coincident with the first source pixel entering the filter
//   abort              synchronous cancel of the frame in progress
//   pix_in             filtered pixel stream, valid every cycle
//   wr_en/addr/data    frame-buffer write port (address/data hold while wr_en=0)
//   busy               high while flushing or writing
//   done               one-cycle pulse after the last pixel of a completed frame
module filt_frame_writer #(
    parameter int                DATA_W     = img_proc_pkg::DATA_W,
    parameter int                IMG_W      = img_proc_pkg::IMG_W,
    parameter int                IMG_H      = img_proc_pkg::IMG_H,
    parameter int                ADDR_W     = img_proc_pkg::ADDR_W,
    parameter int                PIPE_LAT   = img_proc_pkg::pipe_lat(IMG_W),
    parameter logic [DATA_W-1:0] BORDER_VAL = '1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] pix_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    import img_proc_pkg::*;

    localparam int X_W = cnt_w(IMG_W);
    localparam int Y_W = cnt_w(IMG_H);

    // The start cycle itself is the first of the PIPE_LAT fill cycles, so the
    // first valid filter output arrives PIPE_LAT cycles after start. WRITE must
    // therefore be entered on that cycle, which leaves PIPE_LAT-1 cycles of
    // FLUSH; the flush counter runs from PIPE_LAT-2 down to 0. With a latency
    // of 0 or 1 there is nothing to discard and FLUSH is skipped.
    localparam bit SKIP_FLUSH = (PIPE_LAT <= 1);
    localparam int FL_W       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int FL_LOAD_I  = (PIPE_LAT > 1) ? PIPE_LAT - 2 : 0;
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FL_LOAD_I);

    frame_state_e state_q;
    frame_state_e state_d;

    logic [FL_W-1:0]   flush_q;
    logic [FL_W-1:0]   flush_d;

    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              done_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] lin;
    logic              eol;
    logic              eof;
    logic              border;

    raster_xy_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_xy (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .x    (x),
        .y    (y),
        .lin  (lin),
        .eol  (eol),
        .eof  (eof)
    );

    // The 3x3 window hangs off the image on the outermost ring of pixels.
    assign border = (x == '0) || eol || (y == '0) || (y == Y_W'(IMG_H - 1));

    assign busy = (state_q == FLUSH) || (state_q == WRITE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SKIP_FLUSH ? WRITE : FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (flush_q == '0) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (eof) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output / datapath next values. The raster counter sits at the origin
    // whenever the block is not writing, so WRITE always starts at 0,0,0.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        done_d    = 1'b0;
        flush_d   = flush_q;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    flush_d = FL_LOAD;
                end
            end
            FLUSH: begin
                if (flush_q != '0) begin
                    flush_d = flush_q - FL_W'(1);
                end
            end
            WRITE: begin
                cnt_clr = 1'b0;
                if (!abort) begin
                    cnt_en    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = lin;
                    wr_data_d = border ? BORDER_VAL : pix_in;
                end
            end
            DONE: begin
                done_d = !abort;
            end
            default: begin
                flush_d = '0;
            end
        endcase
    end

    // Registered outputs and flush counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            flush_q <= '0;
        end else begin
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            done    <= done_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_filt_frame_writer.sv
// Self-checking bench for filt_frame_writer with an 8x4 frame and a 19-cycle fill latency.
// Stimulus drives start/abort/pix_in and feeds a frame-level model that queues expected writes and done pulses.
// A negedge monitor compares busy every cycle and pops the queues whenever a write or done is due.
module tb_filt_frame_writer;

    localparam int DW  = 10;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 5;
    localparam int LAT = 19;
    localparam int N   = W * H;
    localparam int BV  = (1 << DW) - 1;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b1;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    filt_frame_writer #(
        .DATA_W   (DW),
        .IMG_W    (W),
        .IMG_H    (H),
        .ADDR_W   (AW),
        .PIPE_LAT (LAT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .abort   (abort),
        .pix_in  (pix_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  pix_mode = 0;   // 0 random, 1 all zero, 2 cycle index

    // Frame model: an accepted start at cycle s owns cycles s+1 .. s+LAT+N.
    // Pixel n is sampled at s+LAT+n and written one cycle later; the last
    // owned cycle is the done cycle, whose pulse appears one cycle later.
    bit m_act    = 1'b0;
    int m_s      = 0;
    bit exp_busy = 1'b0;

    function automatic bit is_border(input int n);
        int x = n % W;
        int y = n / W;
        return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
    endfunction

    task automatic chk(input string what, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", what, cyc, act, exp);
        end
    endtask

    task automatic model_cycle(input bit st, input bit ab, input int px);
        int end_c = m_s + LAT + N;
        bit idle  = !m_act || (cyc > end_c);
        exp_busy = !idle && (cyc < end_c);
        if (!idle) begin
            if (ab) begin
                m_act = 1'b0;
            end else begin
                int n = cyc - m_s - LAT;
                if (n >= 0 && n < N) begin
                    wq.push_back('{cyc + 1, n, is_border(n) ? BV : px});
                end
                if (cyc == end_c) begin
                    dq.push_back(cyc + 1);
                end
            end
        end else if (st && !ab) begin
            m_act = 1'b1;
            m_s   = cyc;
        end
    endtask

    task automatic step(input bit st, input bit ab);
        int px;
        case (pix_mode)
            1:       px = 0;
            2:       px = cyc % (1 << DW);
            default: px = int'($urandom_range(0, (1 << DW) - 1));
        endcase
        start  = st;
        abort  = ab;
        pix_in = DW'(px);
        model_cycle(st, ab, px);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int target);
        while (cyc < target) step(1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr_en"},   wr_en,   0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"},    busy,    0);
        chk({tag, "_done"},    done,    0);
    endtask

    task automatic reset_pulse(input string tag);
        rstn     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        m_act    = 1'b0;
        exp_busy = 1'b0;
        wq.delete();
        dq.delete();
        #1;
        check_outputs_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rstn) begin
            bit  ew;
            bit  ed;
            wr_t e;
            chk("busy", busy, exp_busy);
            ew = (wq.size() > 0) && (wq[0].cyc == cyc);
            chk("wr_en", wr_en, ew);
            if (ew) begin
                e = wq.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
            end
            ed = (dq.size() > 0) && (dq[0] == cyc);
            chk("done", done, ed);
            if (ed) void'(dq.pop_front());
        end
    end

    initial begin
        int s0;
        int s1;

        #1;
        reset_pulse("reset");

        // Full frame, pixel = cycle index
        pix_mode = 2;
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 60);

        // Border map with an all-zero source
        pix_mode = 1;
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 60);

        // Extra starts while busy are ignored
        pix_mode = 2;
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 10);
        step(1'b1, 1'b0);
        idle_until(s0 + 30);
        step(1'b1, 1'b0);
        idle_until(s0 + 60);

        // Abort mid-WRITE, then restart
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 30);
        step(1'b0, 1'b1);
        idle_until(s0 + 40);
        step(1'b1, 1'b0);
        idle_until(s0 + 100);

        // Abort during FLUSH
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 8);
        step(1'b0, 1'b1);
        idle_until(s0 + 20);

        // Asynchronous reset in WRITE, then a fresh frame
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 25);
        reset_pulse("midreset");
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + 60);

        // Back-to-back: restart in the done-pulse cycle, then one cycle later
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + LAT + N + 1);
        s1 = cyc;
        step(1'b1, 1'b0);
        idle_until(s1 + LAT + N + 2);
        step(1'b1, 1'b0);
        idle_until(cyc + 60);

        // Start in the DONE cycle is ignored; abort in DONE suppresses done
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + LAT + N);
        step(1'b1, 1'b0);
        idle_until(s0 + 60);
        s0 = cyc;
        step(1'b1, 1'b0);
        idle_until(s0 + LAT + N);
        step(1'b0, 1'b1);
        idle_until(s0 + 60);

        // start and abort together in IDLE: nothing happens
        step(1'b1, 1'b1);
        idle_until(cyc + 30);

        // Randomized traffic
        pix_mode = 0;
        repeat (1500) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
        end
        repeat (80) step(1'b0, 1'b0);

        chk("writes_outstanding", wq.size(), 0);
        chk("dones_outstanding", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
